// File: rtl/regfile_wr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_sched_if
//  Purpose  : Writeback request bus and register-file write-port bus for
//             the register-file write scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_wr_sched_if #(
  parameter int NUM_REQ    = 8,
  parameter int NUM_WR     = 6,
  parameter int SRAM_INDEX = 7,
  parameter int SRAM_WIDTH = 32
);
  logic                         init_start_i;
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ*SRAM_INDEX-1:0] req_addr_i;
  logic [NUM_REQ*SRAM_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_WR-1:0]            wr_we_o;
  logic [NUM_WR*SRAM_INDEX-1:0] wr_addr_o;
  logic [NUM_WR*SRAM_WIDTH-1:0] wr_data_o;
  logic                         init_done_o;

  // Writeback side: raises requests, observes grants and the write ports.
  modport master (
    output init_start_i, req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, wr_we_o, wr_addr_o, wr_data_o, init_done_o
  );

  // Scheduler side.
  modport slave (
    input  init_start_i, req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, wr_we_o, wr_addr_o, wr_data_o, init_done_o
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_sched
//  Purpose  : Packs up to NUM_REQ writeback requests onto NUM_WR register
//             file write ports (round-robin, same-address serialised) and
//             sweeps zero through the whole file after reset or on command.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wr_sched #(
  parameter int NUM_REQ    = 8,
  parameter int NUM_WR     = 6,
  parameter int SRAM_DEPTH = 128,
  parameter int SRAM_INDEX = 7,
  parameter int SRAM_WIDTH = 32
) (
  input wire               clk,
  input wire               reset,
  regfile_wr_sched_if.slave bus
);

  localparam int c_RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CNT_W = $clog2(NUM_WR + 1);
  localparam int c_PTR_W = $clog2(SRAM_DEPTH + NUM_WR);

  localparam logic [c_CNT_W-1:0] c_NUM_WR_CNT = c_CNT_W'(NUM_WR);
  localparam logic [c_PTR_W-1:0] c_NUM_WR_PTR = c_PTR_W'(NUM_WR);
  localparam logic [c_PTR_W-1:0] c_DEPTH      = c_PTR_W'(SRAM_DEPTH);
  localparam logic [c_RR_W:0]    c_NUM_REQ    = (c_RR_W + 1)'(NUM_REQ);
  localparam logic [c_RR_W-1:0]  c_LAST_REQ   = c_RR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                        r_state;
  logic [c_PTR_W-1:0]            r_clear_ptr;
  logic [c_RR_W-1:0]             r_rr_ptr;
  logic                          r_init_done;
  logic [NUM_WR-1:0]             r_wr_we;
  logic [NUM_WR*SRAM_INDEX-1:0]  r_wr_addr;
  logic [NUM_WR*SRAM_WIDTH-1:0]  r_wr_data;

  logic [SRAM_INDEX-1:0]         w_req_addr [NUM_REQ];
  logic [SRAM_WIDTH-1:0]         w_req_data [NUM_REQ];

  logic [NUM_REQ-1:0]            w_grant;
  logic [c_CNT_W-1:0]            w_cnt;
  logic [c_RR_W-1:0]             w_last;
  logic [c_RR_W-1:0]             w_next_rr;
  logic [NUM_WR-1:0]             w_arb_we;
  logic [NUM_WR*SRAM_INDEX-1:0]  w_arb_addr;
  logic [NUM_WR*SRAM_WIDTH-1:0]  w_arb_data;

  logic [c_PTR_W-1:0]            w_beat_base;
  logic [NUM_WR-1:0]             w_beat_we;
  logic [NUM_WR*SRAM_INDEX-1:0]  w_beat_addr;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_req_addr[i] = bus.req_addr_i[i*SRAM_INDEX +: SRAM_INDEX];
      assign w_req_data[i] = bus.req_data_i[i*SRAM_WIDTH +: SRAM_WIDTH];
    end
  endgenerate

  // Round-robin scan from r_rr_ptr; a requester whose address is already
  // claimed this cycle is skipped so it retries next cycle.
  always_comb begin
    logic [c_RR_W:0]   v_sum;
    logic [c_RR_W-1:0] v_idx;
    logic              v_hit;
    w_grant    = '0;
    w_cnt      = '0;
    w_last     = r_rr_ptr;
    w_arb_we   = '0;
    w_arb_addr = '0;
    w_arb_data = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      v_sum = {1'b0, r_rr_ptr} + (c_RR_W + 1)'(s);
      if (v_sum >= c_NUM_REQ) begin
        v_sum = v_sum - c_NUM_REQ;
      end
      v_idx = v_sum[c_RR_W-1:0];
      v_hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_arb_we[p] && (w_arb_addr[p*SRAM_INDEX +: SRAM_INDEX] == w_req_addr[v_idx])) begin
          v_hit = 1'b1;
        end
      end
      if (bus.req_valid_i[v_idx] && !v_hit && (w_cnt < c_NUM_WR_CNT)) begin
        w_grant[v_idx]                              = 1'b1;
        w_arb_we[w_cnt]                             = 1'b1;
        w_arb_addr[w_cnt*SRAM_INDEX +: SRAM_INDEX]  = w_req_addr[v_idx];
        w_arb_data[w_cnt*SRAM_WIDTH +: SRAM_WIDTH]  = w_req_data[v_idx];
        w_last                                      = v_idx;
        w_cnt                                       = w_cnt + 1'b1;
      end
    end
  end

  assign w_next_rr = (w_last == c_LAST_REQ) ? '0 : w_last + 1'b1;

  // A re-clear command emits beat 0 directly from RUN, so the sweep base
  // is forced to zero there.
  assign w_beat_base = (r_state == ST_RUN) ? '0 : r_clear_ptr;

  generate
    for (genvar p = 0; p < NUM_WR; p++) begin : g_beat
      logic [c_PTR_W-1:0] w_sum;
      assign w_sum        = w_beat_base + c_PTR_W'(p);
      assign w_beat_we[p] = (w_sum < c_DEPTH);
      assign w_beat_addr[p*SRAM_INDEX +: SRAM_INDEX] =
        w_beat_we[p] ? w_sum[SRAM_INDEX-1:0] : '0;
    end
  endgenerate

  assign bus.req_ready_o = ((r_state == ST_RUN) && !bus.init_start_i) ? w_grant : '0;
  assign bus.wr_we_o     = r_wr_we;
  assign bus.wr_addr_o   = r_wr_addr;
  assign bus.wr_data_o   = r_wr_data;
  assign bus.init_done_o = r_init_done;

  // Sweep / run state machine and the registered write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_INIT;
      r_clear_ptr <= '0;
      r_rr_ptr    <= '0;
      r_init_done <= 1'b0;
      r_wr_we     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_clear_ptr >= c_DEPTH) begin
            // Every register has been cleared; one quiet cycle then RUN.
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
            r_wr_we     <= '0;
          end else begin
            r_wr_we     <= w_beat_we;
            r_wr_addr   <= w_beat_addr;
            r_wr_data   <= '0;
            r_clear_ptr <= r_clear_ptr + c_NUM_WR_PTR;
          end
        end
        default: begin
          if (bus.init_start_i) begin
            r_state     <= ST_INIT;
            r_init_done <= 1'b0;
            r_wr_we     <= w_beat_we;
            r_wr_addr   <= w_beat_addr;
            r_wr_data   <= '0;
            r_clear_ptr <= c_NUM_WR_PTR;
          end else begin
            r_wr_we   <= w_arb_we;
            r_wr_addr <= w_arb_addr;
            r_wr_data <= w_arb_data;
            if (|w_grant) begin
              r_rr_ptr <= w_next_rr;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wr_sched
//  Purpose  : Directed self-checking bench for regfile_wr_sched.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wr_sched;

  localparam int NUM_REQ = 8;
  localparam int NUM_WR  = 6;
  localparam int DEPTH   = 128;
  localparam int IW      = 7;
  localparam int DW      = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [NUM_WR-1:0]    e_we;
  logic [NUM_WR*IW-1:0] e_addr;
  logic [NUM_WR*DW-1:0] e_data;

  regfile_wr_sched_if #(.NUM_REQ(NUM_REQ), .NUM_WR(NUM_WR), .SRAM_INDEX(IW), .SRAM_WIDTH(DW)) bus ();

  regfile_wr_sched #(
    .NUM_REQ(NUM_REQ), .NUM_WR(NUM_WR), .SRAM_DEPTH(DEPTH), .SRAM_INDEX(IW), .SRAM_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [IW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr_i[i*IW +: IW] = a;
    bus.req_data_i[i*DW +: DW] = d;
  endtask

  task automatic clr_exp();
    e_we = '0; e_addr = '0; e_data = '0;
  endtask

  task automatic exp_port(input int p, input logic [IW-1:0] a, input logic [DW-1:0] d);
    e_we[p]          = 1'b1;
    e_addr[p*IW +: IW] = a;
    e_data[p*DW +: DW] = d;
  endtask

  // Compare write ports; address/data of disabled ports are don't-care.
  task automatic chk_wr(input string tag);
    logic [NUM_WR*IW-1:0] oa;
    logic [NUM_WR*DW-1:0] od;
    oa = bus.wr_addr_o;
    od = bus.wr_data_o;
    for (int p = 0; p < NUM_WR; p++) begin
      if (!bus.wr_we_o[p]) begin
        oa[p*IW +: IW] = '0;
        od[p*DW +: DW] = '0;
      end
    end
    chk({tag, "_we"},   bus.wr_we_o, e_we);
    chk({tag, "_addr"}, oa, e_addr);
    chk({tag, "_data"}, od, e_data);
  endtask

  // Expects beat 1 on the clock edge after the call; clears init_start.
  task automatic run_sweep(input string tag);
    int hit [DEPTH];
    int once;
    for (int i = 0; i < DEPTH; i++) hit[i] = 0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk);
      #1 bus.init_start_i = 1'b0;
      @(negedge clk);
      clr_exp();
      for (int p = 0; p < NUM_WR; p++) begin
        if (k*NUM_WR + p < DEPTH) exp_port(p, IW'(k*NUM_WR + p), '0);
      end
      chk_wr($sformatf("%s_beat%0d", tag, k));
      chk($sformatf("%s_busy%0d", tag, k), {bus.init_done_o, bus.req_ready_o}, '0);
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus.wr_we_o[p]) hit[int'(bus.wr_addr_o[p*IW +: IW])]++;
      end
    end
    once = 0;
    for (int i = 0; i < DEPTH; i++) if (hit[i] == 1) once++;
    chk({tag, "_cover"}, once, DEPTH);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, bus.init_done_o, 1'b1);
    chk({tag, "_quiet_we"}, bus.wr_we_o, '0);
  endtask

  initial begin
    bus.init_start_i = 1'b0;
    bus.req_valid_i  = '1;
    bus.req_addr_i   = '0;
    bus.req_data_i   = '0;
    clr_exp();

    // Reset state, with requests pending that must not be granted.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_we",   bus.wr_we_o, '0);
    chk("rst_addr", bus.wr_addr_o, '0);
    chk("rst_data", bus.wr_data_o, '0);
    chk("rst_done_rdy", {bus.init_done_o, bus.req_ready_o}, '0);
    bus.req_valid_i = '0;
    reset = 1'b1;
    run_sweep("pon");

    // Full load from rr_ptr = 0.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, IW'(8'h10 + i), 32'h1000 + i);
    bus.req_valid_i = 8'hFF;
    #1 chk("full_rdy1", bus.req_ready_o, 8'h3F);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) set_req(i, IW'(8'h20 + i), 32'h2000 + i);
    @(negedge clk);
    clr_exp();
    for (int p = 0; p < NUM_WR; p++) exp_port(p, IW'(8'h10 + p), 32'h1000 + p);
    chk_wr("full_c1");
    chk("full_rdy2", bus.req_ready_o, 8'hCF);
    @(posedge clk);
    #1 bus.req_valid_i = '0;
    @(negedge clk);
    clr_exp();
    exp_port(0, 7'h16, 32'h1006);
    exp_port(1, 7'h17, 32'h1007);
    exp_port(2, 7'h20, 32'h2000);
    exp_port(3, 7'h21, 32'h2001);
    exp_port(4, 7'h22, 32'h2002);
    exp_port(5, 7'h23, 32'h2003);
    chk_wr("full_c2");
    @(posedge clk);
    @(negedge clk);
    clr_exp();
    chk_wr("idle");

    // Sparse single request from the top requester.
    set_req(7, 7'h7F, 32'hDEADBEEF);
    bus.req_valid_i = 8'h80;
    #1 chk("sparse_rdy", bus.req_ready_o, 8'h80);
    @(posedge clk);
    #1 bus.req_valid_i = '0;
    @(negedge clk);
    clr_exp();
    exp_port(0, 7'h7F, 32'hDEADBEEF);
    chk_wr("sparse");

    // Address collision: requester 1 then requester 4 (rr_ptr now 0).
    set_req(1, 7'h25, 32'hAAAA0001);
    set_req(4, 7'h25, 32'hBBBB0004);
    bus.req_valid_i = 8'h12;
    #1 chk("coll_rdy1", bus.req_ready_o, 8'h02);
    @(posedge clk);
    #1 bus.req_valid_i = 8'h10;
    @(negedge clk);
    clr_exp();
    exp_port(0, 7'h25, 32'hAAAA0001);
    chk_wr("coll_c1");
    chk("coll_rdy2", bus.req_ready_o, 8'h10);
    @(posedge clk);
    #1 bus.req_valid_i = '0;
    @(negedge clk);
    clr_exp();
    exp_port(0, 7'h25, 32'hBBBB0004);
    chk_wr("coll_c2");

    // Re-clear while requesters 0-2 wait (rr_ptr now 5).
    for (int i = 0; i < 3; i++) set_req(i, IW'(8'h30 + i), 32'h3000 + i);
    bus.req_valid_i  = 8'h07;
    bus.init_start_i = 1'b1;
    #1 chk("reclr_rdy0", bus.req_ready_o, 8'h00);
    run_sweep("reclr");
    chk("reclr_rdy_after", bus.req_ready_o, 8'h07);
    @(posedge clk);
    #1 bus.req_valid_i = '0;
    @(negedge clk);
    clr_exp();
    for (int p = 0; p < 3; p++) exp_port(p, IW'(8'h30 + p), 32'h3000 + p);
    chk_wr("reclr_traffic");

    // Asynchronous reset in the middle of a sweep (after beat 10).
    bus.init_start_i = 1'b1;
    @(posedge clk);
    #1 bus.init_start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    clr_exp();
    for (int p = 0; p < NUM_WR; p++) exp_port(p, IW'(54 + p), '0);
    chk_wr("mid_beat10");
    #2 reset = 1'b0;
    #1 chk("mid_rst_now", {bus.init_done_o, bus.wr_we_o, bus.wr_addr_o}, '0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_sweep("mid");

    // rr_ptr must have returned to 0 with the reset.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, IW'(8'h40 + i), 32'h4000 + i);
    bus.req_valid_i = 8'hFF;
    #1 chk("mid_rr_reset", bus.req_ready_o, 8'h3F);
    @(posedge clk);
    #1 bus.req_valid_i = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler and clear sequencer for the 128-entry, 6-write-port physical register file. It collects writeback requests from up to NUM_REQ producers (functional units, load return, etc.) and packs them onto the register file's NUM_WR write ports with round-robin fairness and same-address serialization. After reset, or on command, it sweeps zero into every register before it accepts any traffic. It sits between the writeback stage and the register file's addrNwr_i/weN_i/dataNwr_i inputs.

## Interface
- NUM_REQ, 8, number of writeback requesters
- NUM_WR, 6, number of register-file write ports
- SRAM_DEPTH, 128, register count
- SRAM_INDEX, 7, register address width
- SRAM_WIDTH, 32, data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- init_start_i  in  1  request a full clear sweep; sampled only in RUN
- req_valid_i  in  NUM_REQ  per-requester write request
- req_addr_i  in  NUM_REQ*SRAM_INDEX  requester i's address in slice [i*SRAM_INDEX +: SRAM_INDEX]
- req_data_i  in  NUM_REQ*SRAM_WIDTH  requester i's data in slice [i*SRAM_WIDTH +: SRAM_WIDTH]
- req_ready_o  out  NUM_REQ  grant; a transfer occurs when valid & ready
- wr_we_o  out  NUM_WR  register-file write enables (registered)
- wr_addr_o  out  NUM_WR*SRAM_INDEX  write addresses, packed like req_addr_i (registered)
- wr_data_o  out  NUM_WR*SRAM_WIDTH  write data, packed like req_data_i (registered)
- init_done_o  out  1  high in RUN (registered)

## Operation
- State machine states: INIT and RUN. Reset places the block in INIT with clear_ptr = 0.
- INIT, one beat per cycle:
  - Port k drives we = 1, addr = clear_ptr + k, data = 0, for every k with clear_ptr + k < SRAM_DEPTH.
  - Ports whose address would be >= SRAM_DEPTH drive we = 0.
  - clear_ptr advances by NUM_WR each beat.
  - The beat that covers SRAM_DEPTH-1 is the last. With the defaults this is beat 22 (clear_ptr = 126), where only ports 0 and 1 are active.
  - State goes to RUN after the last beat.
  - req_ready_o is all zero throughout INIT.
- RUN, arbitration each cycle (combinational grant):
  - Scan requesters in order rr_ptr, rr_ptr+1, …, rr_ptr+NUM_REQ-1 (mod NUM_REQ).
  - Grant a valid requester if fewer than NUM_WR grants have been made so far and its address differs from every requester already granted this cycle.
  - A requester blocked by an address match is skipped, not granted, and keeps its place in the scan.
  - The n-th granted requester in scan order drives port n. Unused ports drive we = 0.
- rr_ptr update: if at least one grant, rr_ptr ← (index of last granted requester + 1) mod NUM_REQ. Otherwise it is unchanged.
- init_start_i high in RUN:
  - req_ready_o is forced to 0 that same cycle (no transfers).
  - Next state is INIT with clear_ptr = 0. rr_ptr is preserved.
- Requesters may not withdraw valid or change addr/data while valid & !ready. The block does not check this.
- No two active write ports ever carry the same address in the same cycle, in either state.

## Timing
- Latency: a handshake in cycle t produces the write on wr_* in cycle t+1. Outputs are registered.
- INIT beat timing:
  - The first clear beat appears on wr_* the first cycle after reset deassertion.
  - Default sweep length is ceil(128/6) = 22 cycles.
  - init_done_o rises in the cycle after the last beat is driven.
  - req_ready_o may assert from that same cycle.
- Reset values:
  - wr_we_o = 0, wr_addr_o = 0, wr_data_o = 0.
  - init_done_o = 0, req_ready_o = 0.
  - rr_ptr = 0, clear_ptr = 0, state = INIT.
- Asynchronous reset mid-sweep or mid-traffic: all of the above take effect immediately. In-flight registered writes are dropped (wr_we_o = 0), and the sweep restarts from address 0.
- init_done_o falls in the cycle after init_start_i is sampled in RUN. The writes granted in the cycle before init_start_i still appear; the sweep follows them.

## Test plan
- Power-on sweep: release reset with no requests → 22 consecutive beats cover addresses 0..127 exactly once with data 0. Last beat: ports 0/1 = 126/127, ports 2–5 we = 0. init_done_o = 1 on the 23rd cycle after release.
- Full load: in RUN with rr_ptr = 0, all 8 requesters valid with distinct addresses 0x10..0x17.
  - Cycle 1: requesters 0–5 granted onto ports 0–5 in order; rr_ptr becomes 6.
  - Cycle 2 (requesters keep new requests valid): grant order 6, 7, 0, 1, 2, 3.
- Address collision: requesters 1 and 4 both write 0x25 with data 0xAAAA0001 / 0xBBBB0004, others idle → cycle 1 writes 0x25 = 0xAAAA0001 on port 0. Cycle 2 writes 0x25 = 0xBBBB0004.
- Re-clear under traffic: requesters 0–2 valid when init_start_i pulses → req_ready_o = 0 that cycle. Next 22 cycles are a zero sweep, after which requesters 0–2 are granted.
- Reset mid-sweep: assert reset at beat 10, release → wr_we_o drops to 0 immediately. Sweep restarts at address 0 and init_done_o takes a full 22 beats again.
- Sparse single request: only requester 7 valid, addr 0x7F, data 0xDEADBEEF → port 0 writes 0x7F = 0xDEADBEEF one cycle later. rr_ptr becomes 0.
